// File: rtl/boton_eventos_if.sv
// Bus between the press-event generator and its consumers.
// The design side uses the master modport: it takes the debounced
// button level and drives the event pulses, the pressed level and
// the press count. The slave modport is the consumer's view.
interface boton_eventos_if #(
  parameter int CNT_W = 8
);
  logic             boton;
  logic             pulso;
  logic             largo;
  logic             repeticion;
  logic             presionado;
  logic [CNT_W-1:0] conteo;

  modport master (
    input  boton,
    output pulso,
    output largo,
    output repeticion,
    output presionado,
    output conteo
  );

  modport slave (
    output boton,
    input  pulso,
    input  largo,
    input  repeticion,
    input  presionado,
    input  conteo
  );
endinterface

// File: rtl/boton_eventos.sv
// Press-event generator placed after the button debounce filter.
// Turns the clean button level into single-cycle press, long-press and
// (optionally) auto-repeat pulses, and keeps a wrapping event count.
//
// Optional feature: define BOTON_AUTOREPEAT_EN to build the repeat timer
// and the repeticion pulse. Without it, repeticion is tied low, the
// LONG_HELD state just waits for release and conteo counts presses only.
module boton_eventos #(
  parameter int LONG_CYCLES   = 1000,
  parameter int REPEAT_CYCLES = 250,
  parameter int CNT_W         = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  boton_eventos_if.master  bus
);

  localparam int MAX_CYCLES = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int TMR_W      = $clog2(MAX_CYCLES + 1);

  // The timers hold "edges already counted", so the event fires on the
  // edge that finds the timer one short of the target.
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LONG_HELD
  } state_t;

  state_t           state;
  state_t           state_n;
  logic             boton_q;
  logic [TMR_W-1:0] hold_tmr;
  logic [TMR_W-1:0] hold_tmr_n;
  logic             pulso_q;
  logic             pulso_n;
  logic             largo_q;
  logic             largo_n;
  logic             presionado_q;
  logic [CNT_W-1:0] conteo_q;
  logic [CNT_W-1:0] conteo_n;

`ifdef BOTON_AUTOREPEAT_EN
  localparam logic [TMR_W-1:0] REP_LAST = TMR_W'(REPEAT_CYCLES - 1);

  logic [TMR_W-1:0] rep_tmr;
  logic [TMR_W-1:0] rep_tmr_n;
  logic             rep_q;
  logic             rep_n;
`endif

  // Next-state, timer, pulse and count decisions; at most one pulse per cycle.
  always_comb begin
    state_n    = state;
    hold_tmr_n = hold_tmr;
    pulso_n    = 1'b0;
    largo_n    = 1'b0;
    conteo_n   = conteo_q;
`ifdef BOTON_AUTOREPEAT_EN
    rep_tmr_n  = rep_tmr;
    rep_n      = 1'b0;
`endif
    case (state)
      IDLE: begin
        hold_tmr_n = '0;
`ifdef BOTON_AUTOREPEAT_EN
        rep_tmr_n  = '0;
`endif
        if (bus.boton && !boton_q) begin
          state_n  = PRESSED;
          pulso_n  = 1'b1;
          conteo_n = conteo_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!bus.boton) begin
          state_n    = IDLE;
          hold_tmr_n = '0;
        end else if (hold_tmr == HOLD_LAST) begin
          state_n    = LONG_HELD;
          largo_n    = 1'b1;
          hold_tmr_n = '0;
`ifdef BOTON_AUTOREPEAT_EN
          rep_tmr_n  = '0;
`endif
        end else begin
          hold_tmr_n = hold_tmr + 1'b1;
        end
      end
      LONG_HELD: begin
        if (!bus.boton) begin
          state_n    = IDLE;
          hold_tmr_n = '0;
`ifdef BOTON_AUTOREPEAT_EN
          rep_tmr_n  = '0;
`endif
        end else begin
`ifdef BOTON_AUTOREPEAT_EN
          if (rep_tmr == REP_LAST) begin
            rep_n     = 1'b1;
            rep_tmr_n = '0;
            conteo_n  = conteo_q + 1'b1;
          end else begin
            rep_tmr_n = rep_tmr + 1'b1;
          end
`endif
        end
      end
      default: begin
        state_n    = IDLE;
        hold_tmr_n = '0;
      end
    endcase
  end

  // State, timers and registered outputs; the edge register resets high so
  // a button held through reset must be released before it can fire.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= IDLE;
      boton_q      <= 1'b1;
      hold_tmr     <= '0;
      pulso_q      <= 1'b0;
      largo_q      <= 1'b0;
      presionado_q <= 1'b0;
      conteo_q     <= '0;
    end else begin
      state        <= state_n;
      boton_q      <= bus.boton;
      hold_tmr     <= hold_tmr_n;
      pulso_q      <= pulso_n;
      largo_q      <= largo_n;
      presionado_q <= (state_n != IDLE);
      conteo_q     <= conteo_n;
    end
  end

`ifdef BOTON_AUTOREPEAT_EN
  // Repeat timer and the registered auto-repeat pulse.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rep_tmr <= '0;
      rep_q   <= 1'b0;
    end else begin
      rep_tmr <= rep_tmr_n;
      rep_q   <= rep_n;
    end
  end

  assign bus.repeticion = rep_q;
`else
  assign bus.repeticion = 1'b0;
`endif

  assign bus.pulso      = pulso_q;
  assign bus.largo      = largo_q;
  assign bus.presionado = presionado_q;
  assign bus.conteo     = conteo_q;

endmodule

// File: tb/tb_boton_eventos.sv
// Directed bench for boton_eventos with LONG_CYCLES=10, REPEAT_CYCLES=4,
// CNT_W=4 and a 20 ns clock. Expectations follow BOTON_AUTOREPEAT_EN.
module tb_boton_eventos;

  localparam int LONG_C = 10;
  localparam int REP_C  = 4;
  localparam int CW     = 4;

`ifdef BOTON_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic Clk;
  logic Reset_n;
  int   total;
  int   bad;

  boton_eventos_if #(.CNT_W(CW)) bus ();

  boton_eventos #(
    .LONG_CYCLES  (LONG_C),
    .REPEAT_CYCLES(REP_C),
    .CNT_W        (CW)
  ) dut (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .bus    (bus.master)
  );

  // Free-running 20 ns clock.
  initial begin
    Clk = 1'b0;
    forever #10 Clk = ~Clk;
  end

  // Count one comparison and report it when it disagrees.
  task automatic checkOutput(input string tag, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d want %0d", tag, actual, expected);
    end
  endtask

  // Present a button level for the next rising edge, then settle 1 ns after it.
  task automatic applyStimulus(input logic b);
    bus.boton = b;
    @(posedge Clk);
    #1;
  endtask

  // Reset with the button released, then let boton_q see the low level.
  task automatic resetDut();
    bus.boton = 1'b0;
    Reset_n   = 1'b0;
    #35;
    Reset_n   = 1'b1;
    applyStimulus(1'b0);
    applyStimulus(1'b0);
  endtask

  initial begin
    int exp_cnt;
    total     = 0;
    bad       = 0;
    bus.boton = 1'b0;
    Reset_n   = 1'b0;
    #15;

    // Reset values while Reset_n is low.
    checkOutput("rst_pulso", bus.pulso, 0);
    checkOutput("rst_largo", bus.largo, 0);
    checkOutput("rst_rep", bus.repeticion, 0);
    checkOutput("rst_pres", bus.presionado, 0);
    checkOutput("rst_conteo", bus.conteo, 0);

    // Single-cycle press.
    resetDut();
    checkOutput("idle_pulso", bus.pulso, 0);
    applyStimulus(1'b1);
    checkOutput("tap_pulso", bus.pulso, 1);
    checkOutput("tap_pres", bus.presionado, 1);
    checkOutput("tap_conteo", bus.conteo, 1);
    applyStimulus(1'b0);
    checkOutput("tap_pulso_end", bus.pulso, 0);
    checkOutput("tap_pres_end", bus.presionado, 0);

    // Re-press on the cycle right after a release is a new edge.
    applyStimulus(1'b1);
    checkOutput("repress_pulso", bus.pulso, 1);
    checkOutput("repress_conteo", bus.conteo, 2);
    applyStimulus(1'b0);

    // Short hold of 5 cycles: one pulso, no largo.
    resetDut();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1);
      checkOutput($sformatf("short_pulso_%0d", k), bus.pulso, (k == 0) ? 1 : 0);
      checkOutput($sformatf("short_largo_%0d", k), bus.largo, 0);
      checkOutput($sformatf("short_pres_%0d", k), bus.presionado, 1);
    end
    applyStimulus(1'b0);
    checkOutput("short_pres_rel", bus.presionado, 0);
    checkOutput("short_conteo", bus.conteo, 1);

    // Long hold of 20 cycles: largo at E10, repeats at E14/E18 when enabled.
    resetDut();
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1);
      checkOutput($sformatf("long_pulso_%0d", k), bus.pulso, (k == 0) ? 1 : 0);
      checkOutput($sformatf("long_largo_%0d", k), bus.largo, (k == LONG_C) ? 1 : 0);
      checkOutput($sformatf("long_rep_%0d", k), bus.repeticion,
                  (AR && k > LONG_C && ((k - LONG_C) % REP_C) == 0) ? 1 : 0);
      checkOutput($sformatf("long_pres_%0d", k), bus.presionado, 1);
    end
    exp_cnt = AR ? 3 : 1;
    checkOutput("long_conteo", bus.conteo, exp_cnt);
    applyStimulus(1'b0);
    checkOutput("long_rel_pulso", bus.pulso, 0);
    checkOutput("long_rel_largo", bus.largo, 0);
    checkOutput("long_rel_rep", bus.repeticion, 0);
    checkOutput("long_rel_pres", bus.presionado, 0);
    checkOutput("long_rel_conteo", bus.conteo, exp_cnt);

    // 17 presses wrap the 4-bit count through zero.
    resetDut();
    for (int i = 1; i <= 17; i++) begin
      applyStimulus(1'b1);
      checkOutput($sformatf("wrap_pulso_%0d", i), bus.pulso, 1);
      checkOutput($sformatf("wrap_conteo_%0d", i), bus.conteo, i % 16);
      applyStimulus(1'b1);
      applyStimulus(1'b0);
      applyStimulus(1'b0);
    end

    // Asynchronous reset in the middle of a hold, then held through release.
    resetDut();
    for (int k = 0; k <= 5; k++) begin
      applyStimulus(1'b1);
    end
    checkOutput("mid_pres", bus.presionado, 1);
    #3;
    Reset_n = 1'b0;
    #2;
    checkOutput("async_pres", bus.presionado, 0);
    checkOutput("async_conteo", bus.conteo, 0);
    checkOutput("async_pulso", bus.pulso, 0);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1);
      checkOutput($sformatf("held_pulso_%0d", k), bus.pulso, 0);
      checkOutput($sformatf("held_pres_%0d", k), bus.presionado, 0);
    end
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    checkOutput("after_rst_pulso", bus.pulso, 1);
    checkOutput("after_rst_conteo", bus.conteo, 1);
    applyStimulus(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
